nco_freq_meter: RTL
===================

# nco_freq_meter

Frequency meter that sits downstream of the NCO and recovers its phase-increment word from the produced sin/cos sample stream. It counts rising zero crossings of the sine channel over a fixed window of valid samples and reports the count scaled to a 32-bit phase-increment estimate. It also reports rotation direction from the cosine sign at each crossing. It is used for on-board self-check of NCO programming and in simulation as a closed-loop checker.

## Interface

Parameters:
- DATA_W, 14, sample width, two's complement
- WIN_LOG2, 16, window length is 2^WIN_LOG2 valid samples; legal range 4..31
- HYST, 64, hysteresis threshold magnitude; only used when the hysteresis feature is compiled in

Ports:
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample qualifier; identical meaning to the NCO out_valid
- sin_i  in  DATA_W  sine sample, signed
- cos_i  in  DATA_W  cosine sample, signed
- freq_word_o  out  32  phase-increment estimate of the last completed window
- cross_cnt_o  out  WIN_LOG2+1  raw rising-crossing count of the last completed window
- dir_o  out  1  1 = positive rotation, 0 = negative, for the last window
- meas_valid_o  out  1  one-cycle pulse when the outputs above update

## Operation

- States:
  - PRIME: after reset; the first valid sample is stored as prev and is not counted; go to ACQ.
  - ACQ: each valid sample increments the window counter and is tested for a crossing.
- Crossing without the hysteresis feature: prev < 0 and current >= 0.
- Direction on each crossing:
  - cos_i >= 0 increments up_cnt; otherwise it increments dn_cnt.
  - Both counters are WIN_LOG2+1 bits.
- Window end: on the 2^WIN_LOG2-th valid sample of ACQ, that sample's own crossing is included. Then:
  - cross_cnt_o <= total crossings.
  - freq_word_o <= total << (32-WIN_LOG2). If total == 2^WIN_LOG2, saturate to 0xFFFFFFFF.
  - dir_o <= (up_cnt >= dn_cnt).
  - Counters clear.
  - Stay in ACQ. prev carries across windows, so there is no re-prime and no gap between windows.
- in_valid low: no state changes and no counting. prev is held.
- Samples arriving with in_valid low are ignored completely.
- Outputs hold between pulses.

## Timing

- Reset values: freq_word_o=0, cross_cnt_o=0, dir_o=0, meas_valid_o=0. State returns to PRIME and all counters clear.
- Reset asserted mid-window discards the partial window; no meas_valid_o pulse follows.
- Latency:
  - meas_valid_o is high in the cycle after the edge that samples the final valid sample of a window.
  - The registered outputs change on that same edge.
- The first pulse after reset requires 1 + 2^WIN_LOG2 valid samples, counting the prime sample.
- Input rate: back-to-back in_valid every cycle is supported. No backpressure.
- If reset and in_valid are high together, reset wins.

## Configuration

- Macro: NCO_FREQ_METER_HYST_EN.
- Defined:
  - An armed flag sets when a valid sample is < -HYST.
  - A crossing is counted when armed and sample >= 0; armed then clears.
  - Reset and PRIME clear armed. The armed flag persists across windows.
- Undefined: the plain sign-change rule applies and HYST is unused.

## Test plan

- Plain sign change:
  - Stimulus: WIN_LOG2=8, HYST undefined, in_valid every cycle, sin alternating -100,+100 starting with -100 after the prime sample of -100, cos=+50.
  - Required: cross_cnt_o=128, freq_word_o=0x80000000, dir_o=1, meas_valid_o pulse one cycle after the 257th sample, and again every 256 samples.
- Negative rotation: same stimulus with cos=-50 -> dir_o=0, cross_cnt_o=128.
- Hysteresis:
  - Stimulus: sin alternating -30,+30.
  - With NCO_FREQ_METER_HYST_EN and HYST=64 -> cross_cnt_o=0, freq_word_o=0.
  - Without the macro -> cross_cnt_o=128.
- Closed loop with NCO:
  - Stimulus: NCO with phi_inc=0x47AE147B feeding the meter, WIN_LOG2=16.
  - Required: cross_cnt_o 18350 or 18351; freq_word_o 0x47AE0000 or 0x47AF0000; dir_o=1.
- Gaps and reset:
  - Stimulus: in_valid toggled 1-in-3 on the plain sign-change stimulus.
  - Required: identical counts to the gap-free run; pulse timing is set by the valid count only.
  - Stimulus: reset pulsed after 100 samples of a window.
  - Required: all outputs 0, no pulse, and the next pulse comes 1+256 valid samples after reset release.

Source files
------------

// File: rtl/nco_freq_meter.sv
// Recovers an NCO phase-increment word by counting rising sine zero crossings over 2^WIN_LOG2 valid samples.
// Optional feature macro NCO_FREQ_METER_HYST_EN replaces the plain sign-change test with armed hysteresis.
module nco_freq_meter #(
  parameter int DATA_W   = 14,
  parameter int WIN_LOG2 = 16,
  parameter int HYST     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] sin_i,
  input  logic signed [DATA_W-1:0] cos_i,
  output logic [31:0]              freq_word_o,
  output logic [WIN_LOG2:0]        cross_cnt_o,
  output logic                     dir_o,
  output logic                     meas_valid_o
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam int SHIFT = 32 - WIN_LOG2;
  localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(1) << WIN_LOG2;
  localparam logic signed [DATA_W-1:0] ZERO     = '0;

  typedef enum logic {
    PRIME = 1'b0,
    ACQ   = 1'b1
  } state_t;

  state_t              state_reg,    state_next;
  logic                prev_neg_reg, prev_neg_next;
  logic [WIN_LOG2-1:0] win_cnt_reg,  win_cnt_next;
  logic [CNT_W-1:0]    up_cnt_reg,   up_cnt_next;
  logic [CNT_W-1:0]    dn_cnt_reg,   dn_cnt_next;
  logic [31:0]         freq_reg,     freq_next;
  logic [CNT_W-1:0]    cross_reg,    cross_next;
  logic                dir_reg,      dir_next;
  logic                meas_reg,     meas_next;

  logic             sin_neg;
  logic             cos_pos;
  logic             crossing;
  logic             up_inc;
  logic             dn_inc;
  logic             win_last;
  logic [CNT_W-1:0] up_total;
  logic [CNT_W-1:0] dn_total;
  logic [CNT_W-1:0] cross_total;
  logic [31:0]      freq_scaled;

  assign sin_neg  = (sin_i < ZERO);
  assign cos_pos  = (cos_i >= ZERO);
  assign win_last = &win_cnt_reg;

`ifdef NCO_FREQ_METER_HYST_EN
  localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);
  logic armed_reg, armed_next;
  logic unused_prev;

  // Only the armed flag matters here; the stored sign is kept for symmetry with the plain rule.
  assign unused_prev = prev_neg_reg;
  assign crossing    = armed_reg && !sin_neg;
`else
  logic unused_hyst;

  assign unused_hyst = ^HYST;
  assign crossing    = prev_neg_reg && !sin_neg;
`endif

  assign up_inc      = crossing && cos_pos;
  assign dn_inc      = crossing && !cos_pos;
  assign up_total    = up_cnt_reg + CNT_W'(up_inc);
  assign dn_total    = dn_cnt_reg + CNT_W'(dn_inc);
  assign cross_total = up_total + dn_total;
  assign freq_scaled = (cross_total == FULL_CNT) ? 32'hFFFF_FFFF
                                                 : (32'(cross_total) << SHIFT);

  always_comb begin
    state_next    = state_reg;
    prev_neg_next = prev_neg_reg;
    win_cnt_next  = win_cnt_reg;
    up_cnt_next   = up_cnt_reg;
    dn_cnt_next   = dn_cnt_reg;
    freq_next     = freq_reg;
    cross_next    = cross_reg;
    dir_next      = dir_reg;
    meas_next     = 1'b0;
`ifdef NCO_FREQ_METER_HYST_EN
    armed_next    = armed_reg;
`endif

    case (state_reg)
      PRIME: begin
`ifdef NCO_FREQ_METER_HYST_EN
        armed_next = 1'b0;
`endif
        if (in_valid) begin
          prev_neg_next = sin_neg;
          state_next    = ACQ;
        end
      end

      ACQ: begin
        if (in_valid) begin
          prev_neg_next = sin_neg;
          win_cnt_next  = win_cnt_reg + 1'b1;
`ifdef NCO_FREQ_METER_HYST_EN
          if (crossing) begin
            armed_next = 1'b0;
          end else if (sin_i < HYST_NEG) begin
            armed_next = 1'b1;
          end
`endif
          // The closing sample's own crossing is folded into the reported totals.
          if (win_last) begin
            cross_next  = cross_total;
            freq_next   = freq_scaled;
            dir_next    = (up_total >= dn_total);
            meas_next   = 1'b1;
            up_cnt_next = '0;
            dn_cnt_next = '0;
          end else begin
            up_cnt_next = up_total;
            dn_cnt_next = dn_total;
          end
        end
      end

      default: begin
        state_next = PRIME;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= PRIME;
      prev_neg_reg <= 1'b0;
      win_cnt_reg  <= '0;
      up_cnt_reg   <= '0;
      dn_cnt_reg   <= '0;
      freq_reg     <= '0;
      cross_reg    <= '0;
      dir_reg      <= 1'b0;
      meas_reg     <= 1'b0;
`ifdef NCO_FREQ_METER_HYST_EN
      armed_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      prev_neg_reg <= prev_neg_next;
      win_cnt_reg  <= win_cnt_next;
      up_cnt_reg   <= up_cnt_next;
      dn_cnt_reg   <= dn_cnt_next;
      freq_reg     <= freq_next;
      cross_reg    <= cross_next;
      dir_reg      <= dir_next;
      meas_reg     <= meas_next;
`ifdef NCO_FREQ_METER_HYST_EN
      armed_reg    <= armed_next;
`endif
    end
  end

  assign freq_word_o  = freq_reg;
  assign cross_cnt_o  = cross_reg;
  assign dir_o        = dir_reg;
  assign meas_valid_o = meas_reg;

endmodule
